// File: rtl/game_pkg.sv
// game_pkg: shared state encodings, widths and frame-line default for the game blocks
package game_pkg;
   localparam logic [2:0] ST_I    = 3'b100;
   localparam logic [2:0] ST_GAME = 3'b010;
   localparam logic [2:0] ST_DONE = 3'b001;
   localparam int SCORE_W = 16;
   localparam int STEP_W  = 4;
   localparam logic [9:0] FRAME_LINE_DEF = 10'd524;
   typedef enum logic [2:0] {
      S_I    = ST_I,
      S_GAME = ST_GAME,
      S_DONE = ST_DONE
   } state_t;
endpackage

// File: rtl/game_sequencer_frame_strobe.sv
// frame_strobe: registered one-cycle pulse when the VGA counters hit the frame line
module frame_strobe
   import game_pkg::*;
#(
   parameter logic [9:0] FRAME_LINE = FRAME_LINE_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] hCount,
   input  logic [9:0] vCount,
   output logic       frame
);
   // one frame strobe per pass of the beam over column 0 of the frame line
   always_ff @(posedge clk)
      frame <= rst ? 1'b0 : (hCount == 10'd0 && vCount == FRAME_LINE);
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow FSM, move strobe, jump gating, score and speed ramp
module game_sequencer
   import game_pkg::*;
#(
   parameter logic [9:0]         FRAME_LINE = FRAME_LINE_DEF,
   parameter int                 SCORE_DIV  = 6,
   parameter int                 SCORE_STEP = 100,
   parameter int                 BASE_SPEED = 2,
   parameter int                 MAX_SPEED  = 8,
   parameter int                 DONE_HOLD  = 30,
   parameter logic [SCORE_W-1:0] SCORE_MAX  = 16'd9999
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               up,
   input  logic [9:0]         hCount,
   input  logic [9:0]         vCount,
   input  logic               collision,
   output logic               clear,
   output logic               move_en,
   output logic [STEP_W-1:0]  step,
   output logic               jump,
   output logic [SCORE_W-1:0] score,
   output logic               q_I,
   output logic               q_Game,
   output logic               q_Done
);
   localparam logic [7:0]        DIV_M1  = 8'(SCORE_DIV - 1);
   localparam logic [7:0]        STEP_M1 = 8'(SCORE_STEP - 1);
   localparam logic [7:0]        HOLD    = 8'(DONE_HOLD);
   localparam logic [STEP_W-1:0] BASE    = STEP_W'(BASE_SPEED);
   localparam logic [STEP_W-1:0] MAXS    = STEP_W'(MAX_SPEED);

   state_t              state_q, state_d;
   logic                up_q, rise_q, frame;
   logic [7:0]          frame_cnt_q, frame_cnt_d;
   logic [7:0]          point_cnt_q, point_cnt_d;
   logic [7:0]          hold_cnt_q, hold_cnt_d;
   logic [SCORE_W-1:0]  score_d;
   logic [STEP_W-1:0]   step_d;
   logic                clear_d, move_d, jump_d;

   frame_strobe #(.FRAME_LINE(FRAME_LINE)) u_frame (
      .clk    (clk),
      .rst    (rst),
      .hCount (hCount),
      .vCount (vCount),
      .frame  (frame)
   );

   // registered button edge, FSM state, counters and all outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         up_q        <= 1'b0;
         rise_q      <= 1'b0;
         state_q     <= S_I;
         frame_cnt_q <= '0;
         point_cnt_q <= '0;
         hold_cnt_q  <= '0;
         score       <= '0;
         step        <= BASE;
         clear       <= 1'b0;
         move_en     <= 1'b0;
         jump        <= 1'b0;
      end else begin
         up_q        <= up;
         rise_q      <= up & ~up_q;
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         point_cnt_q <= point_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         score       <= score_d;
         step        <= step_d;
         clear       <= clear_d;
         move_en     <= move_d;
         jump        <= jump_d;
      end
   end

   // next state; collision wins over frame and jump so nothing moves after a hit
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      point_cnt_d = point_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      score_d     = score;
      step_d      = step;
      clear_d     = 1'b0;
      move_d      = 1'b0;
      jump_d      = 1'b0;
      case (state_q)
         S_I: if (rise_q) begin
            state_d     = S_GAME;
            clear_d     = 1'b1;
            score_d     = '0;
            step_d      = BASE;
            frame_cnt_d = '0;
            point_cnt_d = '0;
            hold_cnt_d  = '0;
         end
         S_GAME: if (collision) begin
            state_d    = S_DONE;
            hold_cnt_d = '0;
         end else begin
            jump_d = rise_q;
            if (frame) begin
               move_d      = 1'b1;
               frame_cnt_d = (frame_cnt_q == DIV_M1) ? 8'd0 : frame_cnt_q + 8'd1;
               if (frame_cnt_q == DIV_M1 && score != SCORE_MAX) begin
                  score_d     = score + 1'b1;
                  point_cnt_d = (point_cnt_q == STEP_M1) ? 8'd0 : point_cnt_q + 8'd1;
                  step_d      = (point_cnt_q == STEP_M1 && step < MAXS) ? step + 1'b1 : step;
               end
            end
         end
         S_DONE: begin
            hold_cnt_d = (frame && hold_cnt_q != HOLD) ? hold_cnt_q + 8'd1 : hold_cnt_q;
            state_d    = (rise_q && hold_cnt_q == HOLD) ? S_I : S_DONE;
         end
         default: state_d = S_I;
      endcase
   end

   assign q_I    = state_q[2];
   assign q_Game = state_q[1];
   assign q_Done = state_q[0];
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed checks of game flow, scoring, speed ramp, hold and reset
module tb_game_sequencer;
   logic        clk = 1'b0;
   logic        rst, up, collision;
   logic [9:0]  hCount, vCount;
   logic        clear, move_en, jump, q_I, q_Game, q_Done;
   logic [3:0]  step;
   logic [15:0] score;
   logic        clear2, move_en2, jump2, q_I2, q_Game2, q_Done2;
   logic [3:0]  step2;
   logic [15:0] score2;
   int          n_chk = 0, n_fail = 0;
   int          n_move = 0, n_jump = 0, n_clear = 0;
   int          m0, j0, c0;

   always #5 clk = ~clk;

   game_sequencer dut (
      .clk(clk), .rst(rst), .up(up), .hCount(hCount), .vCount(vCount),
      .collision(collision), .clear(clear), .move_en(move_en), .step(step),
      .jump(jump), .score(score), .q_I(q_I), .q_Game(q_Game), .q_Done(q_Done)
   );

   game_sequencer #(.SCORE_MAX(16'd20), .SCORE_STEP(5), .MAX_SPEED(4)) dut2 (
      .clk(clk), .rst(rst), .up(up), .hCount(hCount), .vCount(vCount),
      .collision(collision), .clear(clear2), .move_en(move_en2), .step(step2),
      .jump(jump2), .score(score2), .q_I(q_I2), .q_Game(q_Game2), .q_Done(q_Done2)
   );

   always @(negedge clk) begin
      if (move_en) n_move++;
      if (jump) n_jump++;
      if (clear) n_clear++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_frame();
      hCount = 10'd0;
      vCount = 10'd524;
      tick(1);
      hCount = 10'd1;
      vCount = 10'd0;
      tick(3);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) do_frame();
   endtask

   task automatic press();
      up = 1'b1;
      tick(4);
      up = 1'b0;
      tick(2);
   endtask

   initial begin
      rst = 1'b1; up = 1'b0; collision = 1'b0; hCount = 10'd1; vCount = 10'd0;
      tick(2);
      chk("rst_state", {29'd0, q_I, q_Game, q_Done}, 32'b100);
      chk("rst_score", score, 0);
      chk("rst_step", step, 2);
      chk("rst_pulses", {clear, move_en, jump}, 0);
      rst = 1'b0;
      tick(1);
      m0 = n_move;
      frames(3);
      chk("idle_state", {29'd0, q_I, q_Game, q_Done}, 32'b100);
      chk("idle_moves", n_move - m0, 0);
      chk("idle_score", score, 0);
      j0 = n_jump; c0 = n_clear;
      up = 1'b1;
      tick(1);
      chk("start_n_game", q_Game, 0);
      chk("start_n_clear", clear, 0);
      tick(1);
      chk("start_n1_game", {29'd0, q_I, q_Game, q_Done}, 32'b010);
      chk("start_n1_clear", clear, 1);
      chk("start_n1_jump", jump, 0);
      tick(1);
      chk("clear_width", clear, 0);
      up = 1'b0;
      tick(2);
      chk("start_clears", n_clear - c0, 1);
      chk("start_jumps", n_jump - j0, 0);
      m0 = n_move;
      hCount = 10'd5; vCount = 10'd524;
      tick(3);
      hCount = 10'd0; vCount = 10'd523;
      tick(3);
      hCount = 10'd1; vCount = 10'd0;
      tick(2);
      chk("partial_match_moves", n_move - m0, 0);
      m0 = n_move; j0 = n_jump;
      for (int i = 0; i < 600; i++) begin
         if (i == 60) begin
            chk("sat_mid_score", score2, 10);
            chk("sat_mid_step", step2, 4);
         end
         if (i == 100 || i == 200) up = 1'b1;
         if (i == 150 || i == 203) up = 1'b0;
         do_frame();
      end
      chk("game_moves", n_move - m0, 600);
      chk("game_score", score, 100);
      chk("game_step", step, 3);
      chk("game_jumps", n_jump - j0, 2);
      chk("game_state", {29'd0, q_I, q_Game, q_Done}, 32'b010);
      chk("sat_score", score2, 20);
      chk("sat_step", step2, 4);
      m0 = n_move;
      hCount = 10'd0; vCount = 10'd524;
      tick(1);
      hCount = 10'd1; vCount = 10'd0;
      collision = 1'b1;
      tick(1);
      collision = 1'b0;
      chk("hit_state", {29'd0, q_I, q_Game, q_Done}, 32'b001);
      chk("hit_move", move_en, 0);
      tick(3);
      chk("hit_moves", n_move - m0, 0);
      chk("hit_score", score, 100);
      j0 = n_jump; m0 = n_move;
      frames(10);
      press();
      chk("early_press_state", {29'd0, q_I, q_Game, q_Done}, 32'b001);
      frames(21);
      chk("done_score", score, 100);
      chk("done_step", step, 3);
      chk("done_moves", n_move - m0, 0);
      press();
      chk("restart_state", {29'd0, q_I, q_Game, q_Done}, 32'b100);
      chk("restart_score", score, 100);
      chk("done_jumps", n_jump - j0, 0);
      press();
      chk("regame_state", {29'd0, q_I, q_Game, q_Done}, 32'b010);
      chk("regame_score", score, 0);
      chk("regame_step", step, 2);
      frames(342);
      chk("pre_rst_score", score, 57);
      hCount = 10'd0; vCount = 10'd524;
      up = 1'b1;
      tick(1);
      hCount = 10'd1; vCount = 10'd0;
      rst = 1'b1;
      tick(1);
      chk("mid_rst_state", {29'd0, q_I, q_Game, q_Done}, 32'b100);
      chk("mid_rst_score", score, 0);
      chk("mid_rst_step", step, 2);
      chk("mid_rst_pulses", {clear, move_en, jump}, 0);
      rst = 1'b0; up = 1'b0;
      tick(2);
      chk("post_rst_pulses", {clear, move_en, jump}, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
